// File: rtl/dw_pkg.sv
// Shared types, constants and helpers for the depthwise 3x3 datapath.
package dw_pkg;
  localparam int CH   = 16;
  localparam int DW   = 16;
  localparam int TAPS = 9;

  typedef logic signed [DW-1:0] act_t;
  typedef act_t [CH-1:0]        pix_t;

  // Scan controller states: real pixels, right-hand pad column, bottom pad row.
  typedef enum logic [1:0] {S_RUN, S_PADC, S_PADR} state_t;

  // Bit offset of channel c, tap k inside a flattened CH x 9 x dw window.
  function automatic int unsigned act_off(input int unsigned c, input int unsigned k,
                                          input int unsigned dw = DW);
    return (c * TAPS + k) * dw;
  endfunction
endpackage

// File: rtl/dw_line_buf.sv
// One image-row pixel delay line; output is the pixel shifted in DEPTH enables ago.
module dw_line_buf #(
  parameter int W     = 256,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] mem;

  // Shift one pixel per enable; contents are never cleared, masking lives upstream.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= d;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign q = mem[DEPTH-1];
endmodule

// File: rtl/dw_window_gen.sv
// Raster pixel stream -> zero-padded 3x3 windows for the depthwise conv stage.
// A virtual scan over (IMG_H+1) x (IMG_W+1) positions lets the extra pad row/column
// flush the last windows; tap validity is derived from the centre position only.
module dw_window_gen #(
  parameter int CH     = dw_pkg::CH,
  parameter int DW     = dw_pkg::DW,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int STRIDE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*DW-1:0]    in_pix,
  output logic                out_valid,
  output logic [CH*9*DW-1:0]  out_act,
  output logic                frame_done
);
  import dw_pkg::*;

  localparam int PW = CH * DW;
  localparam int OW = CH * TAPS * DW;
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);

  localparam logic [CW-1:0] C_PAD  = CW'(IMG_W);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_PAD  = RW'(IMG_H);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  // Last emitted centre: largest multiple of STRIDE inside the image.
  localparam logic [RW-1:0] R_FD   = RW'(((IMG_H - 1) / STRIDE) * STRIDE);
  localparam logic [CW-1:0] C_FD   = CW'(((IMG_W - 1) / STRIDE) * STRIDE);

  state_t                  state_q, state_d;
  logic [RW-1:0]           vr_q, vr_d, r_c;
  logic [CW-1:0]           vc_q, vc_d, c_c;
  logic                    adv, lb_en, emit, last;
  logic [PW-1:0]           cur, lb0_q, lb1_q;
  logic [2:0][2:0][PW-1:0] win_q, win_d;   // [ky][kx]
  logic [OW-1:0]           act_d;

  assign in_ready = (state_q == S_RUN) && !rst;
  // Pad positions advance unconditionally; real ones only on an accepted beat.
  assign adv   = !rst && ((state_q != S_RUN) || in_valid);
  assign cur   = (state_q == S_RUN) ? in_pix : '0;
  // Line buffers only see image columns so each holds exactly one row.
  assign lb_en = adv && (vc_q != C_PAD);
  assign r_c   = vr_q - 1'b1;
  assign c_c   = vc_q - 1'b1;
  assign emit  = adv && (vr_q != '0) && (vc_q != '0) &&
                 ((STRIDE == 1) || (!r_c[0] && !c_c[0]));
  assign last  = (r_c == R_FD) && (c_c == C_FD);

  dw_line_buf #(.W(PW), .DEPTH(IMG_W)) u_lb0 (.clk(clk), .en(lb_en), .d(cur),   .q(lb0_q));
  dw_line_buf #(.W(PW), .DEPTH(IMG_W)) u_lb1 (.clk(clk), .en(lb_en), .d(lb0_q), .q(lb1_q));

  // Scan position and state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      vr_q    <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      vr_q    <= vr_d;
      vc_q    <= vc_d;
    end
  end

  // Next scan position: RUN walks image columns, PADC is one cycle, PADR walks IMG_W+1.
  always_comb begin
    state_d = state_q;
    vr_d    = vr_q;
    vc_d    = vc_q;
    if (adv) begin
      unique case (state_q)
        S_RUN: begin
          if (vc_q == C_LAST) begin
            vc_d    = C_PAD;
            state_d = S_PADC;
          end else begin
            vc_d = vc_q + 1'b1;
          end
        end
        S_PADC: begin
          vc_d = '0;
          if (vr_q == R_LAST) begin
            vr_d    = R_PAD;
            state_d = S_PADR;
          end else begin
            vr_d    = vr_q + 1'b1;
            state_d = S_RUN;
          end
        end
        S_PADR: begin
          if (vc_q == C_PAD) begin
            vr_d    = '0;
            vc_d    = '0;
            state_d = S_RUN;
          end else begin
            vc_d = vc_q + 1'b1;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Window shift: new right column is {row-2, row-1, current}, zeros in the pad column.
  always_comb begin
    win_d = win_q;
    if (adv) begin
      for (int ky = 0; ky < 3; ky++) begin
        win_d[ky][0] = win_q[ky][1];
        win_d[ky][1] = win_q[ky][2];
      end
      win_d[0][2] = (vc_q == C_PAD) ? '0 : lb1_q;
      win_d[1][2] = (vc_q == C_PAD) ? '0 : lb0_q;
      win_d[2][2] = (vc_q == C_PAD) ? '0 : cur;
    end
  end

  // Window register; no reset since every out-of-image tap is masked on the way out.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  // Flatten and zero taps that fall outside the image, judged by the centre (r_c, c_c).
  always_comb begin
    logic ok;
    act_d = '0;
    ok    = 1'b0;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        ok = !((ky == 0) && (r_c == '0))    && !((ky == 2) && (r_c == R_LAST)) &&
             !((kx == 0) && (c_c == '0))    && !((kx == 2) && (c_c == C_LAST));
        for (int ch = 0; ch < CH; ch++) begin
          act_d[act_off(ch, ky*3 + kx, DW) +: DW] = ok ? win_d[ky][kx][ch*DW +: DW] : '0;
        end
      end
    end
  end

  // Registered window output; out_act holds between emissions.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_act    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && last;
      if (emit) out_act <= act_d;
    end
  end
endmodule

// File: tb/tb_dw_window_gen.sv
// Bench for dw_window_gen: stride-1 and stride-2 instances share one input stream;
// windows are checked against a model built straight from the image array.
module tb_dw_window_gen;
  localparam int CH = 16, DW = 16, IW = 8, IH = 8;
  localparam int PW = CH * DW, OW = CH * 9 * DW, NP = IW * IH;

  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [PW-1:0] in_pix = '0;
  logic          rdy1, rdy2, ov1, ov2, fd1o, fd2o;
  logic [OW-1:0] act1, act2;

  always #5 clk = ~clk;

  dw_window_gen #(.CH(CH), .DW(DW), .IMG_W(IW), .IMG_H(IH), .STRIDE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_pix(in_pix),
    .out_valid(ov1), .out_act(act1), .frame_done(fd1o));
  dw_window_gen #(.CH(CH), .DW(DW), .IMG_W(IW), .IMG_H(IH), .STRIDE(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_pix(in_pix),
    .out_valid(ov2), .out_act(act2), .frame_done(fd2o));

  typedef struct {
    string       name;
    int          ph;
    int          dut;
    int          win;
    int          ch;
    int          tap;
    logic [15:0] exp;
  } vec_t;

  int            checks = 0, errors = 0;
  int            cyc = 0, rdy_low = 0;
  int            img [NP][CH];
  int            acc_q[$];
  logic [OW-1:0] got1[$], got2[$], ref1[$], exp_act[$];
  bit            gfd1[$], gfd2[$], exp_fd[$];
  vec_t          tv[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov1) begin got1.push_back(act1); gfd1.push_back(fd1o); end
    if (ov2) begin got2.push_back(act2); gfd2.push_back(fd2o); end
    if (!rst && !rdy1) rdy_low++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, a, e);
    end
  endtask

  task automatic cmp_win(input string nm, input int idx, input logic [OW-1:0] a,
                         input logic [OW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      for (int i = 0; i < CH*9; i++)
        if (a[i*DW +: DW] !== e[i*DW +: DW]) begin
          $display("FAIL %s win %0d ch %0d tap %0d got %h exp %h", nm, idx, i/9, i%9,
                   a[i*DW +: DW], e[i*DW +: DW]);
          break;
        end
    end
  endtask

  task automatic cmp_q(input string nm, input logic [OW-1:0] g[$], input logic [OW-1:0] e[$]);
    int n;
    chk({nm, "_count"}, g.size(), e.size());
    n = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < n; i++) cmp_win(nm, i, g[i], e[i]);
  endtask

  task automatic cmp_fd(input string nm, input bit g[$], input bit e[$]);
    int n;
    n = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", nm, i), 64'(g[i]), 64'(e[i]));
  endtask

  // Reference windows: every centre on the stride grid, taps read from the image
  // array with out-of-image coordinates replaced by zero.
  task automatic build(input int s, input int nf);
    logic [OW-1:0] v;
    int lr, lc, rr, cc;
    exp_act.delete(); exp_fd.delete();
    lr = ((IH-1)/s)*s; lc = ((IW-1)/s)*s;
    for (int f = 0; f < nf; f++)
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++)
          if (r % s == 0 && c % s == 0) begin
            v = '0;
            for (int ky = 0; ky < 3; ky++)
              for (int kx = 0; kx < 3; kx++) begin
                rr = r - 1 + ky; cc = c - 1 + kx;
                if (rr >= 0 && rr < IH && cc >= 0 && cc < IW)
                  for (int ch = 0; ch < CH; ch++)
                    v[(ch*9 + ky*3 + kx)*DW +: DW] = 16'(img[rr*IW + cc][ch]);
              end
            exp_act.push_back(v);
            exp_fd.push_back(r == lr && c == lc);
          end
  endtask

  task automatic drive_pix(input int p, input int maxgap);
    int g, t;
    g = $urandom_range(maxgap, 0);
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    for (int c = 0; c < CH; c++) in_pix[c*DW +: DW] = 16'(img[p][c]);
    in_valid = 1'b1;
    t = 0;
    while (!rdy1 && t < 50) begin @(negedge clk); t++; end
    if (!rdy1) begin
      checks++; errors++;
      $display("FAIL ready_timeout beat %0d waited %0d cycles", p, t);
    end
    chk("ready_match", 64'(rdy2), 64'(rdy1));
    acc_q.push_back(cyc);
    @(negedge clk);
  endtask

  task automatic send(input int nbeats, input int maxgap);
    for (int i = 0; i < nbeats; i++) drive_pix(i % NP, maxgap);
    in_valid = 1'b0;
  endtask

  task automatic clear_caps();
    got1.delete(); got2.delete(); gfd1.delete(); gfd2.delete(); acc_q.delete();
  endtask

  task automatic apply_tv(input int ph);
    logic [OW-1:0] w;
    logic [63:0]   val;
    foreach (tv[i]) if (tv[i].ph == ph) begin
      val = 'x;
      if (tv[i].dut == 1 && tv[i].win < got1.size()) begin w = got1[tv[i].win]; val = 64'(w[(tv[i].ch*9 + tv[i].tap)*DW +: DW]); end
      if (tv[i].dut == 2 && tv[i].win < got2.size()) begin w = got2[tv[i].win]; val = 64'(w[(tv[i].ch*9 + tv[i].tap)*DW +: DW]); end
      chk(tv[i].name, val, 64'(tv[i].exp));
    end
  endtask

  initial begin
    tv.push_back('{"w0_t0", 0, 1, 0, 0, 0, 16'd0});
    tv.push_back('{"w0_t1", 0, 1, 0, 0, 1, 16'd0});
    tv.push_back('{"w0_t2", 0, 1, 0, 0, 2, 16'd0});
    tv.push_back('{"w0_t3", 0, 1, 0, 0, 3, 16'd0});
    tv.push_back('{"w0_t6", 0, 1, 0, 0, 6, 16'd0});
    tv.push_back('{"w0_t4", 0, 1, 0, 0, 4, 16'd0});
    tv.push_back('{"w0_t5", 0, 1, 0, 0, 5, 16'd16});
    tv.push_back('{"w0_t7", 0, 1, 0, 0, 7, 16'd128});
    tv.push_back('{"w0_t8", 0, 1, 0, 0, 8, 16'd144});
    tv.push_back('{"w63_t4", 0, 1, 63, 0, 4, 16'd1008});
    tv.push_back('{"w63_t5", 0, 1, 63, 0, 5, 16'd0});
    tv.push_back('{"w63_t7", 0, 1, 63, 0, 7, 16'd0});
    tv.push_back('{"w63_t8", 0, 1, 63, 0, 8, 16'd0});
    tv.push_back('{"s2_c22_t0", 0, 2, 5, 3, 0, 16'd147});
    tv.push_back('{"s2_c22_t4", 0, 2, 5, 3, 4, 16'd291});
    tv.push_back('{"neg_w0_t0", 1, 1, 0, 0, 0, 16'h0000});
    tv.push_back('{"neg_w0_t3", 1, 1, 0, 0, 3, 16'h0000});
    tv.push_back('{"neg_w0_t4", 1, 1, 0, 0, 4, 16'hFFFF});
    tv.push_back('{"neg_w0_t5", 1, 1, 0, 0, 5, 16'hFFFF});
    tv.push_back('{"neg_w0_t7", 1, 1, 0, 0, 7, 16'hFFFF});
    tv.push_back('{"neg_w0_t8", 1, 1, 0, 0, 8, 16'hFFFF});
    tv.push_back('{"neg_w27_t0", 1, 1, 27, 5, 0, 16'hFFFF});
    tv.push_back('{"neg_w27_t8", 1, 1, 27, 5, 8, 16'hFFFF});

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(ov1), 64'd0);
    chk("rst_out_act_zero", 64'(act1 == '0), 64'd1);
    chk("rst_frame_done", 64'(fd1o), 64'd0);
    chk("rst_in_ready", 64'(rdy1), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic: two back-to-back gap-free frames, pixel p channel c = p*16+c.
    for (int p = 0; p < NP; p++) for (int c = 0; c < CH; c++) img[p][c] = p*16 + c;
    clear_caps();
    send(2*NP, 0);
    repeat (20) @(negedge clk);
    build(1, 2); cmp_q("s1_basic", got1, exp_act); cmp_fd("s1_fd", gfd1, exp_fd);
    build(2, 2); cmp_q("s2_basic", got2, exp_act); cmp_fd("s2_fd", gfd2, exp_fd);
    chk("frame_cycles", 64'(acc_q[NP] - acc_q[0]), 64'd81);
    apply_tv(0);
    ref1 = got1;

    // Random gaps, same image: output must match the gap-free run exactly.
    clear_caps(); rdy_low = 0;
    send(2*NP, 5);
    repeat (20) @(negedge clk);
    cmp_q("gap_vs_gapfree", got1, ref1);
    chk("ready_low_cycles", 64'(rdy_low), 64'd34);

    // Random pixel data with gaps, both strides against the model.
    for (int p = 0; p < NP; p++) for (int c = 0; c < CH; c++) img[p][c] = int'($urandom_range(16'hFFFF, 0));
    clear_caps();
    send(NP, 3);
    repeat (20) @(negedge clk);
    build(1, 1); cmp_q("s1_rand", got1, exp_act); cmp_fd("s1_rand_fd", gfd1, exp_fd);
    build(2, 1); cmp_q("s2_rand", got2, exp_act); cmp_fd("s2_rand_fd", gfd2, exp_fd);

    // All channels -1.
    for (int p = 0; p < NP; p++) for (int c = 0; c < CH; c++) img[p][c] = 16'hFFFF;
    clear_caps();
    send(NP, 0);
    repeat (20) @(negedge clk);
    build(1, 1); cmp_q("s1_neg", got1, exp_act);
    apply_tv(1);

    // Reset after 30 beats, then a fresh frame.
    for (int p = 0; p < NP; p++) for (int c = 0; c < CH; c++) img[p][c] = p*16 + c;
    clear_caps();
    send(30, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(ov1), 64'd0);
    chk("post_rst_out_act_zero", 64'(act1 == '0), 64'd1);
    chk("post_rst_frame_done", 64'(fd1o), 64'd0);
    rst = 1'b0;
    clear_caps();
    repeat (10) @(negedge clk);
    chk("post_rst_no_window", 64'(got1.size()), 64'd0);
    send(NP, 0);
    repeat (20) @(negedge clk);
    build(1, 1); cmp_q("s1_after_rst", got1, exp_act); cmp_fd("s1_after_rst_fd", gfd1, exp_fd);
    if (got1.size() > 0) cmp_win("after_rst_first_vs_basic", 0, got1[0], ref1[0]);
    else chk("after_rst_first_present", 64'd0, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dw_window_gen.md
Name: dw_window_gen

Overview:
- Producer for the depthwise 3x3 layers. Accepts a raster-order pixel stream, one beat per pixel carrying all CH channels.
- Builds zero-padded ("same") 3x3 windows for every output position and presents each as one flattened CH x 9 x DW vector with a single-cycle valid.
- Drives the valid/input_act pair of the downstream dw conv stage. That stage has no backpressure, so this block never stalls on its output.

Parameters:
- CH, 16, channels per pixel
- DW, 16, activation width in bits (signed two's complement)
- IMG_W, 8, input image width in pixels (>=2)
- IMG_H, 8, input image height in pixels (>=2)
- STRIDE, 1, output stride; legal values are 1 or 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input pixel beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_pix  in  CH*DW  pixel; channel c at [c*DW +: DW]
- out_valid  out  1  window valid (single-cycle pulse)
- out_act  out  CH*9*DW  window; channel c tap k at [(c*9+k)*DW +: DW]
- frame_done  out  1  single-cycle pulse with the last window of a frame

Behaviour:
- Clocking and reset: one clock domain. rst is synchronous and active-high.
- Reset values: out_valid=0, out_act=0, frame_done=0, in_ready=0 during reset. Position counters return to (0,0) and the FSM returns to RUN. Line buffer contents are not cleared (see masking rule).
- Tap order: k = ky*3+kx, with ky=0 as the top row and kx=0 as the left column.
- Tap value: tap(ky,kx) for a window centred at (r,c) is pixel(r-1+ky, c-1+kx) when that pixel lies inside the image, otherwise all zeros. Masking comes from the row/col counters only, never from stored data.
- Virtual scan: the block walks positions (vr,vc) over vr in 0..IMG_H and vc in 0..IMG_W, raster order, one position per advance.
  - Real position (vr<IMG_H and vc<IMG_W): advances only on in_valid && in_ready, and stores the beat.
  - Pad position (vr==IMG_H or vc==IMG_W): advances every cycle, consumes nothing, inserts zero.
- FSM states:
  - RUN: at a real position; in_ready=1. Go to PADC after accepting vc=IMG_W-1.
  - PADC: at vc=IMG_W; in_ready=0; one cycle. Go to PADR if vr==IMG_H-1, else to RUN at vc=0, vr+1.
  - PADR: at vr=IMG_H; in_ready=0; IMG_W+1 cycles. Then go to RUN at (0,0).
- Emission: on an advance at (vr,vc) with vr>=1 and vc>=1, window centre (r,c)=(vr-1,vc-1) is complete. It is emitted when r%STRIDE==0 and c%STRIDE==0.
- Latency: out_valid and out_act are registered, asserted the cycle after the advancing edge. out_act holds its value until the next emission.
- frame_done: asserted with the emission for centre (IMG_H-1, IMG_W-1) when STRIDE=1. For STRIDE=2 it is asserted with the last emitted centre (largest even r, largest even c).
- Storage: two line buffers of IMG_W pixels plus a 3x3xCH window shift register. Pad positions shift in zeros.
- Throughput: with continuous in_valid a frame takes IMG_H*IMG_W + IMG_H + IMG_W + 1 cycles. The next frame's first beat is accepted the cycle after PADR exits.
- Gaps: in_valid low in RUN freezes all state; no windows are emitted during the gap.
- Reset mid-frame: the partial frame is discarded and the next accepted beat is pixel (0,0). No stale window is emitted, because of the counter-based masking.

Decomposition:
- Package dw_pkg: CH, DW, TAPS=9, typedef act_t (logic signed [DW-1:0]), typedef pix_t (act_t [CH-1:0]).
- The package also provides a function for flattened slice offsets (c*9+k)*DW, shared with the conv stages.
- Sub-module dw_line_buf: one IMG_W-deep pixel delay line with shift-enable, instantiated twice.

Test Plan:
- Stimulus convention: 8x8 frame, STRIDE=1, continuous in_valid; channel c of pixel p has value p*16+c.
- Basic 8x8, STRIDE=1 -> exactly 64 out_valid pulses and 81 cycles per frame.
  - Window 0 ch0: taps 0,1,2,3,6 = 0; tap4=0, tap5=16, tap7=128, tap8=144.
  - frame_done only with window 63, whose taps 5,7,8 are 0.
- STRIDE=2, same frame -> 16 windows, centres (0,0),(0,2)..(6,6).
  - Window for centre (2,2) ch3: tap0=147 (pixel 9), tap4=291 (pixel 18).
- Random in_valid gaps of 0-5 cycles, 2 back-to-back frames -> windows bit-identical to the gap-free run.
  - in_ready low for exactly 8 PADC cycles and 9 PADR cycles per frame.
- Negative values (-1 in all channels) -> centre window taps all 0xFFFF.
  - Corner window (0,0) has 0xFFFF only at taps 4,5,7,8.
- rst asserted for 1 cycle after 30 beats, then a fresh frame -> no out_valid during or after rst until a new window completes.
  - First window matches the basic test.
  - out_act=0 and frame_done=0 on the cycle after rst.
